// File: rtl/mcdf_reg_pkg.sv
// Package for the MCDF register slave.
// Holds the command encoding, the register address map, the ctrl field
// layout and the ctrl reset value. The slave and its per-channel ctrl
// register both import it.
package mcdf_reg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    WR   = 2'b10,
    RSV  = 2'b11
  } cmd_e;

  localparam logic [7:0] CTRL_BASE = 8'h00;
  localparam logic [7:0] STAT_BASE = 8'h10;
  localparam logic [7:0] ERR_ADDR  = 8'h20;

  // ctrl register field layout
  localparam int unsigned CTRL_W   = 6;
  localparam int unsigned EN_OFF   = 0;
  localparam int unsigned PRIO_OFF = 1;
  localparam int unsigned PRIO_W   = 2;
  localparam int unsigned LEN_OFF  = 3;
  localparam int unsigned LEN_W    = 3;

  // en=1, prio=3, len=0
  localparam logic [31:0] CTRL_RST = 32'h0000_0007;

  function automatic logic word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/mcdf_ctrl_reg.sv
// One channel's control register.
// Ports:
//   clk, rstn : clock, asynchronous active-low reset
//   wr_en     : write strobe (legal WR decoded to this channel)
//   wr_data   : low ctrl bits of the write data
//   ctrl      : full register value (for read-back)
//   en/prio/len : decoded fields driven to the datapath
module mcdf_ctrl_reg
  import mcdf_reg_pkg::*;
(
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr_en,
  input  logic [CTRL_W-1:0] wr_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic              en,
  output logic [PRIO_W-1:0] prio,
  output logic [LEN_W-1:0]  len
);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ctrl <= CTRL_RST[CTRL_W-1:0];
    end else if (wr_en) begin
      ctrl <= wr_data;
    end
  end

  assign en   = ctrl[EN_OFF];
  assign prio = ctrl[PRIO_OFF +: PRIO_W];
  assign len  = ctrl[LEN_OFF +: LEN_W];

endmodule

// File: rtl/mcdf_reg_slave.sv
// MCDF register-bank slave on the register command bus.
// Decodes IDLE/RD/WR, holds per-channel ctrl registers, exposes live FIFO
// margin status and a saturating illegal-access counter. Reads return data
// the cycle after the RD command; every other cycle the read bus is zero.
// Ports:
//   clk, rstn      : clock, asynchronous active-low reset
//   cmd            : 00 IDLE, 01 RD, 10 WR, 11 reserved
//   cmd_addr       : word-aligned byte address
//   cmd_data_m2s   : write data
//   cmd_data_s2m   : registered read data
//   ch_margin      : per-channel free FIFO slots (8 bits each)
//   ch_en/ch_prio/ch_len : per-channel config to the datapath
module mcdf_reg_slave
  import mcdf_reg_pkg::*;
#(
  parameter int unsigned CH_NUM = 3,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ERR_W  = 16
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          cmd,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [DATA_W-1:0]   cmd_data_m2s,
  output logic [DATA_W-1:0]   cmd_data_s2m,
  input  logic [CH_NUM*8-1:0] ch_margin,
  output logic [CH_NUM-1:0]   ch_en,
  output logic [CH_NUM*2-1:0] ch_prio,
  output logic [CH_NUM*3-1:0] ch_len
);

  cmd_e              cmd_c;
  logic [CTRL_W-1:0] ctrl_q [CH_NUM];
  logic [CH_NUM-1:0] ctrl_we;
  logic [ERR_W-1:0]  err_cnt;
  logic              illegal;
  logic              err_clr;
  logic [DATA_W-1:0] rd_data;
  logic              unused_wdata;

  assign cmd_c        = cmd_e'(cmd);
  assign unused_wdata = ^cmd_data_m2s[DATA_W-1:CTRL_W];

  always_comb begin
    int unsigned addr_i;
    int unsigned ctrl_off;
    int unsigned stat_off;
    logic        aligned;
    logic        hit_ctrl;
    logic        hit_stat;
    logic        hit_err;

    addr_i   = 32'(cmd_addr);
    // Offsets wrap to huge values below their base, so a single "<" bound
    // checks both ends of each window.
    ctrl_off = addr_i - 32'(CTRL_BASE);
    stat_off = addr_i - 32'(STAT_BASE);
    aligned  = word_aligned(cmd_addr[1:0]);
    hit_ctrl = aligned && (ctrl_off < 4 * CH_NUM);
    hit_stat = aligned && (stat_off < 4 * CH_NUM);
    hit_err  = aligned && (addr_i == 32'(ERR_ADDR));

    rd_data = '0;
    ctrl_we = '0;
    for (int unsigned i = 0; i < CH_NUM; i++) begin
      if (hit_ctrl && ctrl_off == 4 * i) begin
        rd_data = DATA_W'(ctrl_q[i]);
        ctrl_we[i] = (cmd_c == WR);
      end
      if (hit_stat && stat_off == 4 * i) begin
        rd_data = DATA_W'(ch_margin[8*i +: 8]);
      end
    end
    if (hit_err) begin
      rd_data = DATA_W'(err_cnt);
    end

    err_clr = (cmd_c == WR) && hit_err;
    unique case (cmd_c)
      RD:      illegal = !(hit_ctrl || hit_stat || hit_err);
      WR:      illegal = !(hit_ctrl || hit_err);
      RSV:     illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
    mcdf_ctrl_reg u_ctrl (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (ctrl_we[g]),
      .wr_data (cmd_data_m2s[CTRL_W-1:0]),
      .ctrl    (ctrl_q[g]),
      .en      (ch_en[g]),
      .prio    (ch_prio[PRIO_W*g +: PRIO_W]),
      .len     (ch_len[LEN_W*g +: LEN_W])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      err_cnt <= '0;
    end else if (err_clr) begin
      err_cnt <= '0;
    end else if (illegal && err_cnt != '1) begin
      err_cnt <= err_cnt + 1'b1;
    end
  end

  // Unmapped reads already yield zero from the mux, so any RD just captures it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_data_s2m <= '0;
    end else begin
      cmd_data_s2m <= (cmd_c == RD) ? rd_data : '0;
    end
  end

endmodule
